uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Transmit-side controller for the UART transmitter behind the peripheral bus. Buffers bytes written by the CPU in a small FIFO and sequences them into the transmitter one at a time. For each byte it issues a one-cycle `tx_en` pulse with `tx_data`, then tracks `tx_status` until the transmitter is idle again. This lets software queue several bytes without polling the transmit-done flag for each one.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2–64.
- `BUSY_TIMEOUT`, 16: cycles allowed for `tx_status` to fall after a `tx_en` pulse.

Ports:
- `clk`  in  1  system clock; all state is rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scheduler may launch new bytes.
- `flush`  in  1  one-cycle request to empty the FIFO.
- `push`  in  1  write strobe for `push_data`.
- `push_data`  in  8  byte to queue.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `tx_data`  out  8  byte presented to the transmitter.
- `tx_en`  out  1  one-cycle launch pulse to the transmitter.
- `tx_status`  in  1  transmitter idle when high; low while shifting.
- `done`  out  1  one-cycle pulse when a byte finishes.
- `overflow`  out  1  sticky: a push arrived while the FIFO was full.
- `timeout_err`  out  1  sticky: `tx_status` did not fall within `BUSY_TIMEOUT` cycles.
- `clr_err`  in  1  clears both sticky flags.

## Operation
- FIFO write:
  - `push` while `!full` stores `push_data` at the tail.
  - `push` while `full` drops the byte and sets `overflow`. This applies even if a pop happens in the same cycle.
- FIFO read: a pop happens only on an IDLE→LAUNCH decision. Push and pop in the same cycle leave `count` unchanged.
- `flush`:
  - Zeroes `count` and both pointers next edge.
  - Does not abort a byte already launched.
  - `flush` and `push` in the same cycle: the flush wins and the pushed byte is discarded. `overflow` is not set.
- FSM states (localparam codes):
  - IDLE: if `enable && !empty && tx_status`, load `tx_data` from the head, pop, assert `tx_en`, go to WAIT_BUSY. Otherwise stay.
  - WAIT_BUSY: `tx_en` is low. Increment `to_cnt` each cycle.
    - `tx_status==0`: go to WAIT_DONE.
    - `to_cnt==BUSY_TIMEOUT-1` with `tx_status` still high: set `timeout_err`, pulse `done`, go to IDLE. The byte is treated as sent.
  - WAIT_DONE: on `tx_status==1`, pulse `done` and go to IDLE.
- `enable` deasserted mid-byte: the current byte completes normally. No new launch until `enable` is high again.
- `clr_err` and a new error event in the same cycle: the set wins.
- Reset values:
  - state IDLE.
  - `tx_en`, `done`, `overflow`, `timeout_err` all 0.
  - `tx_data` 8'h00, `count` 0, `empty` 1, `full` 0.
  - pointers 0, `to_cnt` 0.
- Reset mid-byte: all state is dropped and the FIFO is emptied. The transmitter itself is not reset by this block.

## Timing
- Every output is registered. `full`, `empty` and `count` reflect the result of the previous edge.
- Push at edge N: the byte is visible in `count` after edge N.
- Launch latency from an empty FIFO: push at edge N, launch decision at edge N+1, `tx_en` high for the cycle after N+1.
- `tx_en` width is exactly one cycle. `tx_data` is stable from the `tx_en` cycle until the next launch.
- Minimum spacing between launches is 3 cycles: IDLE, WAIT_BUSY, WAIT_DONE.
- `done` is asserted in the cycle following the edge that returns the FSM to IDLE.
- Back-to-back bytes: the next launch is evaluated in the IDLE cycle right after `done`.
- Pointers wrap modulo `DEPTH`. `count` saturates naturally at `DEPTH`, with no wrap.

## Structure
- Package `uart_sched_pkg`:
  - FSM state localparams: IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2.
  - Default `DEPTH`/`BUSY_TIMEOUT` constants.
- Sub-module `byte_fifo`:
  - Synchronous, `DEPTH`×8.
  - Ports: push/pop/flush, `count`/`full`/`empty`, and head data with combinational read of the head entry.
- Top level: FSM, timeout counter and sticky flags.

## Test plan
- Reset, then push 8'hA5 with `tx_status`=1, `enable`=1 → `tx_en` one cycle with `tx_data`=8'hA5. Drive `tx_status` low 10 cycles then high → one `done` pulse, `count`=0.
- `enable`=0, push 0x01..0x08 → `full`=1, `count`=8. A 9th push sets `overflow`. Raise `enable` → bytes 0x01..0x08 are launched in order, each only after `tx_status` returns high.
- After a launch, hold `tx_status` high → `timeout_err`=1 after 16 cycles in WAIT_BUSY, `done` pulses. Then `clr_err` → flag 0.
- In WAIT_DONE, push and `flush` in the same cycle → `count`=0, `overflow`=0. The in-flight byte still produces `done`.
- Full FIFO with a push in the same cycle as a launch pop → `count`=7, `overflow`=1.
- Assert `reset` low during WAIT_DONE → all outputs at reset values immediately. After release, no `tx_en` until a new push.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared state encoding and default sizing for the UART transmit scheduler.
package uart_sched_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } sched_state_e;

   localparam int DEF_DEPTH        = 8;
   localparam int DEF_BUSY_TIMEOUT = 16;

endpackage

// File: rtl/byte_fifo.sv
// DEPTH x 8 synchronous FIFO with registered occupancy flags and a combinational head read.
module byte_fifo
   import uart_sched_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [7:0]                 push_data,
   output logic [7:0]                 head_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [CW-1:0] cnt_nxt;
   logic          wr_ok, rd_ok;

   // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
   assign wr_ok   = push && !full && !flush;
   assign rd_ok   = pop && !empty;
   assign cnt_nxt = count + CW'(wr_ok) - CW'(rd_ok);
   assign head_data = mem[rptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (wr_ok) wptr <= wptr + AW'(1);
         if (rd_ok) rptr <= rptr + AW'(1);
         count <= cnt_nxt;
         full  <= (cnt_nxt == CW'(DEPTH));
         empty <= (cnt_nxt == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues CPU bytes and launches them one at a time into the UART transmitter,
// tracking tx_status through busy and back to idle.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int DEPTH        = DEF_DEPTH,
   parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic                   flush,
   input  logic                   push,
   input  logic [7:0]             push_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [7:0]             tx_data,
   output logic                   tx_en,
   input  logic                   tx_status,
   output logic                   done,
   output logic                   overflow,
   output logic                   timeout_err,
   input  logic                   clr_err
);

   localparam int TW = $clog2(BUSY_TIMEOUT + 1);

   sched_state_e  state;
   logic [TW-1:0] to_cnt;
   logic [7:0]    head_data;
   logic          launch, ovf_evt, to_evt;

   assign launch  = (state == IDLE) && enable && !empty && tx_status;
   assign ovf_evt = push && full && !flush;
   assign to_evt  = (state == WAIT_BUSY) && tx_status && (to_cnt == TW'(BUSY_TIMEOUT - 1));

   byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (launch),
      .flush     (flush),
      .push_data (push_data),
      .head_data (head_data),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         to_cnt  <= '0;
         tx_data <= 8'h00;
         tx_en   <= 1'b0;
         done    <= 1'b0;
      end else begin
         tx_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (launch) begin
                  tx_data <= head_data;
                  tx_en   <= 1'b1;
                  to_cnt  <= '0;
                  state   <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               to_cnt <= to_cnt + TW'(1);
               if (!tx_status) begin
                  state <= WAIT_DONE;
               end else if (to_evt) begin
                  // Transmitter never went busy: count the byte as sent.
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            WAIT_DONE: begin
               if (tx_status) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky flags: a new event in the same cycle as clr_err keeps the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (ovf_evt)      overflow <= 1'b1;
         else if (clr_err) overflow <= 1'b0;
         if (to_evt)       timeout_err <= 1'b1;
         else if (clr_err) timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed-vector bench for uart_tx_scheduler with hand-computed expectations.
module tb_uart_tx_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0, flush = 1'b0, push = 1'b0, clr_err = 1'b0;
   logic [7:0] push_data = 8'h00;
   logic       tx_status = 1'b1;
   logic       full, empty, tx_en, done, overflow, timeout_err;
   logic [3:0] count;
   logic [7:0] tx_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.DEPTH(8), .BUSY_TIMEOUT(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .flush       (flush),
      .push        (push),
      .push_data   (push_data),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .tx_data     (tx_data),
      .tx_en       (tx_en),
      .tx_status   (tx_status),
      .done        (done),
      .overflow    (overflow),
      .timeout_err (timeout_err),
      .clr_err     (clr_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until tx_en is seen (bounded), then check the launched byte.
   task automatic wait_launch(input string tag, input logic [7:0] exp);
      bit seen = 0;
      for (int i = 0; i < 8 && !seen; i++) begin
         tick();
         if (tx_en) seen = 1;
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      chk({tag, "_data"}, 32'(tx_data), 32'(exp));
   endtask

   task automatic push_byte(input logic [7:0] d);
      push = 1'b1;
      push_data = d;
      tick();
      push = 1'b0;
   endtask

   task automatic reset_outs(input string tag);
      chk({tag, "_tx_en"}, 32'(tx_en), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_ovf"}, 32'(overflow), 32'd0);
      chk({tag, "_to"}, 32'(timeout_err), 32'd0);
      chk({tag, "_data"}, 32'(tx_data), 32'h00);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_empty"}, 32'(empty), 32'd1);
      chk({tag, "_full"}, 32'(full), 32'd0);
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      reset_outs("rst");
      reset = 1'b1;
      tick();

      // Single byte, 10 busy cycles
      enable = 1'b1;
      tx_status = 1'b1;
      push_byte(8'hA5);
      chk("b1_count", 32'(count), 32'd1);
      chk("b1_tx_en_early", 32'(tx_en), 32'd0);
      tick();
      chk("b1_tx_en", 32'(tx_en), 32'd1);
      chk("b1_data", 32'(tx_data), 32'hA5);
      chk("b1_count0", 32'(count), 32'd0);
      tick();
      chk("b1_tx_en_width", 32'(tx_en), 32'd0);
      tx_status = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("b1_no_done", 32'(done), 32'd0);
      end
      tx_status = 1'b1;
      tick();
      chk("b1_done", 32'(done), 32'd1);
      chk("b1_data_hold", 32'(tx_data), 32'hA5);
      tick();
      chk("b1_done_width", 32'(done), 32'd0);
      chk("b1_empty", 32'(empty), 32'd1);

      // Fill with enable low, overflow, then drain in order
      enable = 1'b0;
      for (int i = 1; i <= 8; i++) push_byte(8'(i));
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd8);
      chk("fill_no_launch", 32'(tx_en), 32'd0);
      push_byte(8'h09);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_count", 32'(count), 32'd8);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);
      enable = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         wait_launch($sformatf("drain%0d", k), 8'(k));
         tx_status = 1'b0;
         for (int j = 0; j < 3; j++) begin
            tick();
            chk("drain_busy_no_launch", 32'(tx_en), 32'd0);
         end
         tx_status = 1'b1;
         tick();
         chk($sformatf("drain%0d_done", k), 32'(done), 32'd1);
      end
      chk("drain_empty", 32'(empty), 32'd1);

      // Busy timeout: tx_status never falls
      push_byte(8'h5A);
      tick();
      chk("to_launch", 32'(tx_en), 32'd1);
      for (int i = 0; i < 15; i++) tick();
      chk("to_not_yet", 32'(timeout_err), 32'd0);
      chk("to_no_done_yet", 32'(done), 32'd0);
      tick();
      chk("to_set", 32'(timeout_err), 32'd1);
      chk("to_done", 32'(done), 32'd1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("to_clr", 32'(timeout_err), 32'd0);

      // Flush + push in WAIT_DONE
      push_byte(8'h11);
      tick();
      chk("fl_launch", 32'(tx_en), 32'd1);
      tx_status = 1'b0;
      tick();
      push_byte(8'h22);
      chk("fl_count1", 32'(count), 32'd1);
      push = 1'b1;
      push_data = 8'h33;
      flush = 1'b1;
      tick();
      push = 1'b0;
      flush = 1'b0;
      chk("fl_count0", 32'(count), 32'd0);
      chk("fl_empty", 32'(empty), 32'd1);
      chk("fl_ovf", 32'(overflow), 32'd0);
      tx_status = 1'b1;
      tick();
      chk("fl_done", 32'(done), 32'd1);
      tick();
      chk("fl_no_launch", 32'(tx_en), 32'd0);

      // Full FIFO: push in the same cycle as a launch pop
      enable = 1'b0;
      for (int i = 0; i < 8; i++) push_byte(8'h40 + 8'(i));
      chk("fp_full", 32'(full), 32'd1);
      enable = 1'b1;
      push = 1'b1;
      push_data = 8'h99;
      tick();
      push = 1'b0;
      enable = 1'b0;
      chk("fp_tx_en", 32'(tx_en), 32'd1);
      chk("fp_data", 32'(tx_data), 32'h40);
      chk("fp_count", 32'(count), 32'd7);
      chk("fp_ovf", 32'(overflow), 32'd1);
      tx_status = 1'b0;
      tick();
      tx_status = 1'b1;
      tick();
      chk("fp_done", 32'(done), 32'd1);
      flush = 1'b1;
      clr_err = 1'b1;
      tick();
      flush = 1'b0;
      clr_err = 1'b0;
      chk("fp_flushed", 32'(count), 32'd0);

      // Reset during WAIT_DONE
      enable = 1'b1;
      push_byte(8'h77);
      tick();
      chk("rm_launch", 32'(tx_en), 32'd1);
      tx_status = 1'b0;
      tick();
      push_byte(8'h78);
      chk("rm_count1", 32'(count), 32'd1);
      reset = 1'b0;
      #1;
      reset_outs("rm");
      tick();
      reset = 1'b1;
      tx_status = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rm_no_launch", 32'(tx_en), 32'd0);
      end
      push_byte(8'h55);
      tick();
      chk("rm_new_launch", 32'(tx_en), 32'd1);
      chk("rm_new_data", 32'(tx_data), 32'h55);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
